// File: rtl/midi_pkg.sv
// Shared MIDI constants, event payload and parser state encoding.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;
    localparam logic [3:0] SYS        = 4'hF;

    localparam int unsigned NOTE_W = 7;
    localparam int unsigned VEL_W  = 7;
    localparam int unsigned AGE_W  = 3;
    localparam int unsigned SLOT_W = 16;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_ON   = 2'd1,
        EV_OFF  = 2'd2
    } midi_ev_kind_e;

    typedef struct packed {
        midi_ev_kind_e     kind;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  vel;
    } midi_event_t;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_WAIT_D1 = 2'd1,
        PS_WAIT_D2 = 2'd2
    } parser_state_e;

    // Realtime bytes 0xF8-0xFF may interleave anywhere and carry no state.
    function automatic logic is_realtime(input logic [7:0] b);
        return &b[7:3];
    endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// Byte-stream MIDI parser with running status; emits registered note events.
module midi_byte_parser
    import midi_pkg::*;
#(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned OMNI    = 0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  midi_byte_in,
    input  logic        midi_byte_valid_in,
    output midi_event_t ev_out
);

    parser_state_e     state_q, state_nxt;
    logic [7:0]        status_q, status_nxt;
    logic [NOTE_W-1:0] d1_q, d1_nxt;
    midi_event_t       ev_q, ev_nxt;
    logic              chan_ok_c;

    assign chan_ok_c = (OMNI != 0) || (status_q[3:0] == 4'(CHANNEL));
    assign ev_out    = ev_q;

    // Parser state, running status, first data byte and pending event.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= PS_IDLE;
            status_q <= 8'h00;
            d1_q     <= '0;
            ev_q     <= '0;
        end else begin
            state_q  <= state_nxt;
            status_q <= status_nxt;
            d1_q     <= d1_nxt;
            ev_q     <= ev_nxt;
        end
    end

    // Next-state decode; the event register holds for exactly one cycle.
    always_comb begin
        state_nxt  = state_q;
        status_nxt = status_q;
        d1_nxt     = d1_q;
        ev_nxt     = '0;
        if (midi_byte_valid_in && !is_realtime(midi_byte_in)) begin
            if (midi_byte_in[7]) begin
                if (midi_byte_in[7:4] == SYS) begin
                    state_nxt  = PS_IDLE;
                    status_nxt = 8'h00;
                end else begin
                    state_nxt  = PS_WAIT_D1;
                    status_nxt = midi_byte_in;
                end
            end else begin
                case (state_q)
                    PS_WAIT_D1: begin
                        if (status_q[7:4] != PROG && status_q[7:4] != CHAN_PRESS) begin
                            d1_nxt    = midi_byte_in[6:0];
                            state_nxt = PS_WAIT_D2;
                        end
                    end
                    PS_WAIT_D2: begin
                        state_nxt = PS_WAIT_D1;
                        if (chan_ok_c) begin
                            if (status_q[7:4] == NOTE_ON && midi_byte_in[6:0] != 7'd0) begin
                                ev_nxt.kind = EV_ON;
                                ev_nxt.note = d1_q;
                                ev_nxt.vel  = midi_byte_in[6:0];
                            end else if (status_q[7:4] == NOTE_ON || status_q[7:4] == NOTE_OFF) begin
                                ev_nxt.kind = EV_OFF;
                                ev_nxt.note = d1_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Voice slot table with LRU stealing, fed by the MIDI byte parser.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 5,
    parameter int unsigned CHANNEL    = 0,
    parameter int unsigned OMNI       = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [7:0]                   midi_byte_in,
    input  logic                         midi_byte_valid_in,
    output logic [NUM_VOICES*SLOT_W-1:0] midi_burst_data_out,
    output logic [NUM_VOICES-1:0]        on_array_out,
    output logic                         midi_burst_change_out,
    output logic                         voices_full_out,
    output logic [7:0]                   steal_count_out
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    midi_event_t ev;

    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_nxt [NUM_VOICES];
    logic [VEL_W-1:0]      vel_q [NUM_VOICES];
    logic [VEL_W-1:0]      vel_nxt [NUM_VOICES];
    logic [AGE_W-1:0]      age_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_nxt [NUM_VOICES];
    logic [NUM_VOICES-1:0] on_q, on_nxt;
    logic [7:0]            steal_q, steal_nxt;
    logic                  change_q, change_nxt;
    logic                  full_q;

    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      old_idx;
    logic [AGE_W-1:0]      old_age;
    logic [IDX_W-1:0]      tgt_idx;

    midi_byte_parser #(
        .CHANNEL (CHANNEL),
        .OMNI    (OMNI)
    ) u_parser (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .midi_byte_in       (midi_byte_in),
        .midi_byte_valid_in (midi_byte_valid_in),
        .ev_out             (ev)
    );

    // Slot lookup: matching active note, lowest free slot, oldest slot.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        old_idx    = '0;
        old_age    = age_q[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hit && on_q[i] && note_q[i] == ev.note) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!free_found && !on_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = IDX_W'(i);
            end
        end
        tgt_idx = free_found ? free_idx : old_idx;
    end

    // Table update for the pending event.
    always_comb begin
        note_nxt   = note_q;
        vel_nxt    = vel_q;
        age_nxt    = age_q;
        on_nxt     = on_q;
        steal_nxt  = steal_q;
        change_nxt = 1'b0;
        if (ev.kind == EV_ON) begin
            change_nxt = 1'b1;
            if (hit) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (IDX_W'(i) == hit_idx) vel_nxt[i] = ev.vel;
                end
            end else begin
                if (!free_found && steal_q != 8'hFF) steal_nxt = steal_q + 8'd1;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (IDX_W'(i) == tgt_idx) begin
                        on_nxt[i]   = 1'b1;
                        note_nxt[i] = ev.note;
                        vel_nxt[i]  = ev.vel;
                        age_nxt[i]  = '0;
                    end else if (on_q[i]) begin
                        age_nxt[i] = (age_q[i] >= AGE_MAX) ? AGE_MAX : age_q[i] + AGE_W'(1);
                    end
                end
            end
        end else if (ev.kind == EV_OFF && hit) begin
            change_nxt = 1'b1;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == hit_idx) begin
                    on_nxt[i]   = 1'b0;
                    note_nxt[i] = '0;
                    vel_nxt[i]  = '0;
                    age_nxt[i]  = '0;
                end
            end
        end
    end

    // Table and status registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
            on_q     <= '0;
            steal_q  <= 8'h00;
            change_q <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_nxt[i];
                vel_q[i]  <= vel_nxt[i];
                age_q[i]  <= age_nxt[i];
            end
            on_q     <= on_nxt;
            steal_q  <= steal_nxt;
            change_q <= change_nxt;
            full_q   <= &on_nxt;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        assign midi_burst_data_out[g*SLOT_W +: SLOT_W] = {1'b0, note_q[g], 1'b0, vel_q[g]};
    end

    assign on_array_out          = on_q;
    assign midi_burst_change_out = change_q;
    assign voices_full_out       = full_q;
    assign steal_count_out       = steal_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: message-level model checked every cycle plus directed literals.
module tb_midi_voice_alloc;

    localparam int NV    = 5;
    localparam int TB_CH = 0;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic [7:0]       midi_byte_in;
    logic             midi_byte_valid_in;
    logic [NV*16-1:0] midi_burst_data_out;
    logic [NV-1:0]    on_array_out;
    logic             midi_burst_change_out;
    logic             voices_full_out;
    logic [7:0]       steal_count_out;

    int n_vec = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    midi_voice_alloc #(
        .NUM_VOICES (NV),
        .CHANNEL    (TB_CH),
        .OMNI       (0)
    ) dut (
        .clk_in                (clk_in),
        .rst_n_in              (rst_n_in),
        .midi_byte_in          (midi_byte_in),
        .midi_byte_valid_in    (midi_byte_valid_in),
        .midi_burst_data_out   (midi_burst_data_out),
        .on_array_out          (on_array_out),
        .midi_burst_change_out (midi_burst_change_out),
        .voices_full_out       (voices_full_out),
        .steal_count_out       (steal_count_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- message-level model ----------------
    int m_note [NV];
    int m_vel  [NV];
    int m_cnt  [NV];   // allocations seen since this slot was filled
    bit m_on   [NV];
    int m_steal;
    bit m_change;
    int m_rs;          // running status byte, -1 when none
    bit m_have_d1;
    int m_d1;
    int p_kind;        // 0 none, 1 note on, 2 note off
    int p_n, p_v;

    function automatic int eff_age(input int c);
        return (c < NV - 1) ? c : NV - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0; m_vel[i] = 0; m_cnt[i] = 0; m_on[i] = 0;
        end
        m_steal = 0; m_change = 0; m_rs = -1; m_have_d1 = 0; m_d1 = 0;
        p_kind = 0; p_n = 0; p_v = 0;
    endtask

    task automatic model_on(input int n, input int v);
        int s;
        s = -1;
        for (int i = 0; i < NV; i++) if (m_on[i] && m_note[i] == n) s = i;
        m_change = 1;
        if (s >= 0) begin
            m_vel[s] = v;
            return;
        end
        for (int i = NV - 1; i >= 0; i--) if (!m_on[i]) s = i;
        if (s < 0) begin
            s = 0;
            for (int i = 1; i < NV; i++) if (eff_age(m_cnt[i]) > eff_age(m_cnt[s])) s = i;
            if (m_steal < 255) m_steal++;
        end
        for (int i = 0; i < NV; i++) if (m_on[i]) m_cnt[i]++;
        m_on[s] = 1; m_note[s] = n; m_vel[s] = v; m_cnt[s] = 0;
    endtask

    task automatic model_off(input int n);
        for (int i = 0; i < NV; i++) begin
            if (m_on[i] && m_note[i] == n) begin
                m_on[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_cnt[i] = 0;
                m_change = 1;
            end
        end
    endtask

    task automatic model_parse(input int b);
        int hi;
        hi = m_rs >> 4;
        if (b >= 'hF8) begin
        end else if (b >= 'hF0) begin
            m_rs = -1; m_have_d1 = 0;
        end else if (b >= 'h80) begin
            m_rs = b; m_have_d1 = 0;
        end else if (m_rs >= 0) begin
            if (hi == 'hC || hi == 'hD) begin
            end else if (!m_have_d1) begin
                m_d1 = b; m_have_d1 = 1;
            end else begin
                m_have_d1 = 0;
                if ((m_rs & 15) == TB_CH && (hi == 8 || hi == 9)) begin
                    p_n = m_d1; p_v = b;
                    p_kind = (hi == 9 && b != 0) ? 1 : 2;
                end
            end
        end
    endtask

    // Model advances on the same edges as the design: parsed event lands one edge later.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            model_reset();
        end else begin
            m_change = 0;
            if (p_kind == 1) model_on(p_n, p_v);
            else if (p_kind == 2) model_off(p_n);
            p_kind = 0;
            if (midi_byte_valid_in) model_parse(int'(midi_byte_in));
        end
    end

    function automatic logic [NV*16-1:0] exp_data();
        logic [NV*16-1:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[i*16 +: 16] = 16'((m_note[i] << 8) | m_vel[i]);
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_on();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = m_on[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [NV*16-1:0] act, input logic [NV*16-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk_in);
            #1;
            if (done) break;
            chk("model data", midi_burst_data_out, exp_data());
            chk("model on", NV*16'(on_array_out), NV*16'(exp_on()));
            chk("model change", NV*16'(midi_burst_change_out), NV*16'(m_change));
            chk("model full", NV*16'(voices_full_out), NV*16'(&exp_on()));
            chk("model steal", NV*16'(steal_count_out), NV*16'(m_steal));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk_in);
        midi_byte_in       = b;
        midi_byte_valid_in = 1'b1;
        @(negedge clk_in);
        midi_byte_valid_in = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, " data"}, midi_burst_data_out, '0);
        chk({name, " on"}, NV*16'(on_array_out), '0);
        chk({name, " chg"}, NV*16'(midi_burst_change_out), '0);
        chk({name, " full"}, NV*16'(voices_full_out), '0);
        chk({name, " steal"}, NV*16'(steal_count_out), '0);
    endtask

    initial begin
        rst_n_in           = 1'b0;
        midi_byte_in       = 8'h00;
        midi_byte_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        chk_zero("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // 1: single note on, pulse exactly one cycle
        send(8'h90); send(8'h3C); send(8'h64);
        settle();
        chk("t1 slot0", 80'(midi_burst_data_out[15:0]), 80'(16'h3C64));
        chk("t1 on", 80'(on_array_out), 80'(5'b00001));
        chk("t1 pulse", 80'(midi_burst_change_out), 80'(1'b1));
        settle();
        chk("t1 pulse end", 80'(midi_burst_change_out), 80'(1'b0));

        // 2: running status, velocity overwrite, note off
        do_reset();
        send(8'h90); send(8'h40); send(8'h50); send(8'h43); send(8'h50);
        settle();
        chk("t2 slot0", 80'(midi_burst_data_out[15:0]), 80'(16'h4050));
        chk("t2 slot1", 80'(midi_burst_data_out[31:16]), 80'(16'h4350));
        chk("t2 on", 80'(on_array_out), 80'(5'b00011));
        send(8'h43); send(8'h22);
        settle();
        chk("t2 revel", 80'(midi_burst_data_out[31:16]), 80'(16'h4322));
        chk("t2 revel pulse", 80'(midi_burst_change_out), 80'(1'b1));
        send(8'h80); send(8'h40); send(8'h00);
        settle();
        chk("t2 off slot0", 80'(midi_burst_data_out[15:0]), 80'(16'h0000));
        chk("t2 off on", 80'(on_array_out), 80'(5'b00010));

        // 3: sixth note steals the oldest slot; off for the stolen note is a no-op
        do_reset();
        send(8'h90);
        for (int k = 0; k < 6; k++) begin
            send(8'(60 + k)); send(8'h40);
        end
        settle();
        chk("t3 steal slot0", 80'(midi_burst_data_out[15:0]), 80'(16'h4140));
        chk("t3 steals", 80'(steal_count_out), 80'(8'd1));
        chk("t3 full", 80'(voices_full_out), 80'(1'b1));
        send(8'h80); send(8'h3C); send(8'h00);
        settle();
        chk("t3 absent off pulse", 80'(midi_burst_change_out), 80'(1'b0));
        chk("t3 absent off on", 80'(on_array_out), 80'(5'b11111));

        // 4: velocity zero frees the slot; realtime bytes interleaved
        do_reset();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        settle();
        chk("t4 on rt", 80'(midi_burst_data_out[15:0]), 80'(16'h3C64));
        send(8'h3C); send(8'hF8); send(8'h00);
        settle();
        chk("t4 vel0 on", 80'(on_array_out), 80'(5'b00000));
        chk("t4 vel0 pulse", 80'(midi_burst_change_out), 80'(1'b1));

        // 5: channel filter, program change, system byte kills running status
        do_reset();
        send(8'h91); send(8'h3C); send(8'h64);
        settle();
        chk("t5 other chan", 80'(on_array_out), 80'(5'b00000));
        send(8'hC0); send(8'h05); send(8'h05);
        settle();
        chk("t5 prog", 80'(midi_burst_change_out), 80'(1'b0));
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'hF0); send(8'h3C); send(8'h00);
        settle();
        chk("t5 sys idle", 80'(midi_burst_data_out[15:0]), 80'(16'h3C64));
        chk("t5 sys on", 80'(on_array_out), 80'(5'b00001));

        // 6: reset mid-message discards it and running status
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk_zero("t6 in reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        send(8'h40); send(8'h40);
        settle();
        settle();
        chk_zero("t6 after");

        // 7: steal counter saturates at 255
        do_reset();
        send(8'h90);
        for (int k = 0; k < 265; k++) begin
            send(8'(k % 100)); send(8'h10);
        end
        settle();
        chk("t7 steal sat", 80'(steal_count_out), 80'(8'd255));
        chk("t7 full", 80'(voices_full_out), 80'(1'b1));

        // 8: saturated age tie resolves to the lowest index
        do_reset();
        send(8'h90);
        for (int k = 0; k < 5; k++) begin
            send(8'(10 + k)); send(8'h01);
        end
        send(8'd10); send(8'h00);
        send(8'd20); send(8'h01);
        send(8'd14); send(8'h00);
        for (int k = 21; k < 24; k++) begin
            send(8'(k)); send(8'h01);
            send(8'(k)); send(8'h00);
        end
        send(8'd24); send(8'h01);
        send(8'd30); send(8'h05);
        settle();
        chk("t8 tie slot0", 80'(midi_burst_data_out[15:0]), 80'(16'h1E05));
        chk("t8 tie slot1", 80'(midi_burst_data_out[31:16]), 80'(16'h0B01));
        chk("t8 steals", 80'(steal_count_out), 80'(8'd1));

        repeat (3) @(negedge clk_in);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
